// File: rtl/pipe_pkg.sv
// Shared state encoding, per-boundary control widths and bubble encodings
// for the flow-controlled pipeline stage registers.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_MAIN  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_t;

   localparam int unsigned IF_ID_CTRL_W  = 1;
   localparam int unsigned ID_EX_CTRL_W  = 12;
   localparam int unsigned EX_MEM_CTRL_W = 6;
   localparam int unsigned MEM_WB_CTRL_W = 3;

   // Bubbles must never assert RegWrite/MemWrite downstream, so all fields stay zero.
   localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_BUBBLE  = '0;
   localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_BUBBLE  = '0;
   localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_BUBBLE = '0;
   localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_BUBBLE = '0;

   function automatic logic [1:0] occupancy_of(input stage_state_t st);
      case (st)
         ST_MAIN: return 2'd1;
         ST_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One {valid, data, ctrl} holding register of a pipeline stage.
// Priority: reset > flush > load > clear; flush/clear keep data, write bubble ctrl.
module pipe_skid_entry
   import pipe_pkg::*;
#(
   parameter int unsigned            DATA_W      = 64,
   parameter int unsigned            CTRL_W      = 12,
   parameter logic [CTRL_W-1:0]      BUBBLE_CTRL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic              flush,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = BUBBLE_CTRL;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = d_data;
         ctrl_d  = d_ctrl;
      end else if (clear) begin
         valid_d = 1'b0;
         ctrl_d  = BUBBLE_CTRL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= BUBBLE_CTRL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush and an optional 2-entry skid buffer;
// with SKID=1 in_ready comes straight from a flop.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W      = 64,
   parameter int unsigned       CTRL_W      = 12,
   parameter int unsigned       SKID        = 1,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   stage_state_t      state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              in_hs, out_hs;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_data, skid_data, main_src_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;

   assign out_hs = main_valid & out_ready;
   assign in_hs  = in_valid & in_ready;

   // Next state and entry controls; flush overrides whatever the handshakes asked for.
   always_comb begin
      state_d    = state_q;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_hs) begin
               main_load = 1'b1;
               state_d   = ST_MAIN;
            end
         end
         ST_MAIN: begin
            if (out_hs && in_hs) begin
               main_load = 1'b1;
            end else if (out_hs) begin
               main_clear = 1'b1;
               state_d    = ST_EMPTY;
            end else if (in_hs) begin
               skid_load = 1'b1;
               state_d   = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_hs) begin
               main_load  = 1'b1;
               skid_clear = 1'b1;
               state_d    = ST_MAIN;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
      in_ready_d = (SKID != 0) ? (state_d != ST_FULL) : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Main reloads from the skid when it holds the older entry.
   assign main_src_data = skid_valid ? skid_data : in_data;
   assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;

   pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_main (
      .clk    (clk),
      .reset  (reset),
      .load   (main_load),
      .clear  (main_clear),
      .flush  (flush),
      .d_data (main_src_data),
      .d_ctrl (main_src_ctrl),
      .valid  (main_valid),
      .data   (main_data),
      .ctrl   (main_ctrl)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_skid (
            .clk    (clk),
            .reset  (reset),
            .load   (skid_load),
            .clear  (skid_clear),
            .flush  (flush),
            .d_data (in_data),
            .d_ctrl (in_ctrl),
            .valid  (skid_valid),
            .data   (skid_data),
            .ctrl   (skid_ctrl)
         );
         assign in_ready = in_ready_q;
      end else begin : g_noskid
         logic unused_skid_ctl;
         assign unused_skid_ctl = skid_load ^ skid_clear;
         assign skid_valid      = 1'b0;
         assign skid_data       = '0;
         assign skid_ctrl       = BUBBLE_CTRL;
         assign in_ready        = in_ready_q & (~main_valid | out_ready);
      end
   endgenerate

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_ctrl  = main_ctrl;
   assign occupancy = occupancy_of(state_q);

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: a SKID=1 and a SKID=0 instance share stimulus,
// each checked against its own queue of accepted entries.
module tb_pipe_stage_hs;

   localparam logic [11:0] BUB = 12'hA50;
   typedef logic [75:0] item_t;

   logic        clk = 1'b0;
   logic        reset, in_valid, flush, out_ready;
   logic [63:0] in_data;
   logic [11:0] in_ctrl;

   logic        in_ready, out_valid, in_ready0, out_valid0;
   logic [63:0] out_data, out_data0;
   logic [11:0] out_ctrl, out_ctrl0;
   logic [1:0]  occupancy, occupancy0;

   int unsigned n_vec = 0;
   int unsigned n_mis = 0;
   item_t       q1[$];
   item_t       q0[$];
   logic        rdy_ok = 1'b0;
   logic        seen_c7 = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_hs #(.DATA_W(64), .CTRL_W(12), .SKID(1), .BUBBLE_CTRL(BUB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
   );

   pipe_stage_hs #(.DATA_W(64), .CTRL_W(12), .SKID(0), .BUBBLE_CTRL(BUB)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid0),
      .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occupancy0)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Check both instances at the negedge, then advance the models across the coming posedge.
   task automatic sample();
      logic exp_ir1, exp_ir0;
      @(negedge clk);
      exp_ir1 = rdy_ok && (q1.size() < 2);
      exp_ir0 = rdy_ok && (q0.size() == 0 || out_ready);
      chk("in_ready", 128'(in_ready), 128'(exp_ir1));
      chk("out_valid", 128'(out_valid), 128'(q1.size() != 0));
      chk("occupancy", 128'(occupancy), 128'(q1.size()));
      if (q1.size() != 0) chk("out_item", 128'({out_ctrl, out_data}), 128'(q1[0]));
      else                chk("bubble_ctrl", 128'(out_ctrl), 128'(BUB));
      chk("s0_in_ready", 128'(in_ready0), 128'(exp_ir0));
      chk("s0_out_valid", 128'(out_valid0), 128'(q0.size() != 0));
      chk("s0_occupancy", 128'(occupancy0), 128'(q0.size()));
      if (q0.size() != 0) chk("s0_out_item", 128'({out_ctrl0, out_data0}), 128'(q0[0]));
      else                chk("s0_bubble_ctrl", 128'(out_ctrl0), 128'(BUB));
      if (out_valid && out_data == 64'hC7) seen_c7 = 1'b1;
      if (reset) begin
         q1.delete();
         q0.delete();
         rdy_ok = 1'b0;
      end else begin
         rdy_ok = 1'b1;
         if (flush) begin
            q1.delete();
            q0.delete();
         end else begin
            if (q1.size() != 0 && out_ready) void'(q1.pop_front());
            if (in_valid && exp_ir1) q1.push_back({in_ctrl, in_data});
            if (q0.size() != 0 && out_ready) void'(q0.pop_front());
            if (in_valid && exp_ir0) q0.push_back({in_ctrl, in_data});
         end
      end
   endtask

   task automatic cyc(input logic rst, input logic iv, input logic [63:0] d,
                      input logic fl, input logic ordy);
      reset     = rst;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = d[11:0] ^ 12'h3C3;
      flush     = fl;
      out_ready = ordy;
      sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      cyc(0, 0, 0, 0, 1);
      chk("rel_in_ready", 128'(in_ready), 128'(1));

      // Streaming at full rate
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 1, 64'(i), 0, 1);
         chk("stream_data", 128'(out_data), 128'(i));
         chk("stream_occ", 128'(occupancy), 128'(1));
      end
      cyc(0, 0, 0, 0, 1);

      // Stall into FULL, then drain
      cyc(0, 1, 64'hA5, 0, 0);
      cyc(0, 1, 64'hB6, 0, 0);
      chk("stall_occ", 128'(occupancy), 128'(2));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_hold", 128'(out_data), 128'(64'hA5));
      cyc(0, 0, 0, 0, 0);
      chk("stall_hold2", 128'(out_data), 128'(64'hA5));
      cyc(0, 0, 0, 0, 1);
      chk("drain_b", 128'(out_data), 128'(64'hB6));
      cyc(0, 0, 0, 0, 1);
      chk("drain_empty", 128'(out_valid), 128'(0));

      // Flush while FULL with a coinciding input
      cyc(0, 1, 64'h11, 0, 0);
      cyc(0, 1, 64'h22, 0, 0);
      cyc(0, 1, 64'hC7, 1, 0);
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_ctrl", 128'(out_ctrl), 128'(BUB));
      chk("flush_occ", 128'(occupancy), 128'(0));
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
      chk("c7_absent", 128'(seen_c7), 128'(0));

      // Reset while FULL and stalled
      cyc(0, 1, 64'h33, 0, 0);
      cyc(0, 1, 64'h44, 0, 0);
      cyc(1, 1, 64'h55, 0, 0);
      chk("mid_rst_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_data", 128'(out_data), 128'(0));
      chk("mid_rst_ctrl", 128'(out_ctrl), 128'(BUB));
      chk("mid_rst_occ", 128'(occupancy), 128'(0));
      cyc(0, 0, 0, 0, 1);
      chk("mid_rel_ready", 128'(in_ready), 128'(1));

      // Continuous input with out_ready 1,0,1,1 (combinational ready on SKID=0)
      cyc(0, 1, 64'h61, 0, 1);
      cyc(0, 1, 64'h62, 0, 0);
      cyc(0, 1, 64'h63, 0, 1);
      cyc(0, 1, 64'h64, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         cyc(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 3) != 0),
             {$urandom, $urandom}, 1'($urandom_range(0, 31) == 0),
             1'($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
